// File: rtl/apb_master_exe_seq.sv
// ---------------------------------------------------------------------------
// apb_master_exe_seq
//
// APB requester that runs one execution-unit job per accepted start pulse.
// A job is five back-to-back APB transfers:
//   step 0: write addr 0 <- oper
//   step 1: write addr 1 <- argA
//   step 2: write addr 2 <- argB
//   step 3: read  addr 0 -> o_result
//   step 4: read  addr 1 -> o_status (low 4 bits)
// The job ends with a one-cycle o_done pulse. o_err is set when the slave
// answers with PSLVERR or when PREADY stays low for TIMEOUT ACCESS cycles.
//
// Handshake: a transfer completes on the rising edge where PSEL=1,
// PENABLE=1 and PREADY=1. PSLVERR and PRDATA are only looked at on that
// edge; in any other cycle they are ignored.
//
// Ports:
//   i_PCLK, i_PRESET         clock, synchronous active-high reset
//   i_start, i_oper/argA/argB job request and operands (sampled in IDLE)
//   o_busy, o_done           job in progress / job end pulse
//   o_result, o_status, o_err job outcome, held until the next start
//   o_PADDR..o_PWDATA        APB requester outputs (all registered)
//   i_PREADY, i_PRDATA, i_PSLVERR  APB completer responses
// ---------------------------------------------------------------------------
module apb_master_exe_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESET,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_oper,
    input  logic [DATA_WIDTH-1:0] i_argA,
    input  logic [DATA_WIDTH-1:0] i_argB,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [3:0]            o_status,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_PADDR,
    output logic                  o_PSEL,
    output logic                  o_PENABLE,
    output logic                  o_PWRITE,
    output logic [DATA_WIDTH-1:0] o_PWDATA,
    input  logic                  i_PREADY,
    input  logic [DATA_WIDTH-1:0] i_PRDATA,
    input  logic                  i_PSLVERR
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            step_q, step_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] oper_q, oper_d;
    logic [DATA_WIDTH-1:0] arga_q, arga_d;
    logic [DATA_WIDTH-1:0] argb_q, argb_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [3:0]            status_q, status_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tmo_d     = tmo_q;
        oper_d    = oper_q;
        arga_d    = arga_q;
        argb_d    = argb_q;
        result_d  = result_q;
        status_d  = status_q;
        err_d     = err_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    oper_d   = i_oper;
                    arga_d   = i_argA;
                    argb_d   = i_argB;
                    result_d = '0;
                    status_d = '0;
                    err_d    = 1'b0;
                    step_d   = 3'd0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                tmo_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (i_PREADY) begin
                    if (i_PSLVERR) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        if (step_q == 3'd3) result_d = i_PRDATA;
                        if (step_q == 3'd4) status_d = i_PRDATA[3:0];
                        if (step_q < 3'd4) begin
                            step_d  = step_q + 3'd1;
                            state_d = SETUP;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they come out of
        // flops aligned with the state they belong to.
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        done_d    = (state_d == DONE);
        busy_d    = (state_d != IDLE);

        // Address/data are loaded on entry to SETUP and simply held through
        // ACCESS. oper_d etc. are used so step 0 sees the operands being
        // latched in the same edge.
        if (state_d == SETUP) begin
            unique case (step_d)
                3'd0: begin
                    paddr_d  = ADDR_WIDTH'(0);
                    pwrite_d = 1'b1;
                    pwdata_d = oper_d;
                end
                3'd1: begin
                    paddr_d  = ADDR_WIDTH'(1);
                    pwrite_d = 1'b1;
                    pwdata_d = arga_d;
                end
                3'd2: begin
                    paddr_d  = ADDR_WIDTH'(2);
                    pwrite_d = 1'b1;
                    pwdata_d = argb_d;
                end
                3'd3: begin
                    paddr_d  = ADDR_WIDTH'(0);
                    pwrite_d = 1'b0;
                    pwdata_d = '0;
                end
                default: begin
                    paddr_d  = ADDR_WIDTH'(1);
                    pwrite_d = 1'b0;
                    pwdata_d = '0;
                end
            endcase
        end else if (state_d != ACCESS) begin
            paddr_d  = '0;
            pwrite_d = 1'b0;
            pwdata_d = '0;
        end
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            state_q   <= IDLE;
            step_q    <= '0;
            tmo_q     <= '0;
            oper_q    <= '0;
            arga_q    <= '0;
            argb_q    <= '0;
            result_q  <= '0;
            status_q  <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            tmo_q     <= tmo_d;
            oper_q    <= oper_d;
            arga_q    <= arga_d;
            argb_q    <= argb_d;
            result_q  <= result_d;
            status_q  <= status_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_result  = result_q;
    assign o_status  = status_q;
    assign o_err     = err_q;
    assign o_PADDR   = paddr_q;
    assign o_PSEL    = psel_q;
    assign o_PENABLE = penable_q;
    assign o_PWRITE  = pwrite_q;
    assign o_PWDATA  = pwdata_q;

endmodule
